// File: rtl/seq_control.sv
// rtl/seq_control.sv - multi-cycle instruction sequencer for a 16-bit datapath
// Three-process FSM driving memory handshake, datapath enables and a retired-instruction counter.
`timescale 1ns/1ps
module seq_control #(
  parameter int SKIP_MEM = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instruction,
  input  logic             S,
  input  logic             Z,
  input  logic             C,
  input  logic             V,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_w,
  output logic             addr_sel,
  output logic             ir_e,
  output logic             pc_e,
  output logic             pc_sel,
  output logic             ar_e,
  output logic             br_e,
  output logic             alu_e,
  output logic             dr_e,
  output logic             mdr_e,
  output logic             flag_e,
  output logic             reg_w,
  output logic [1:0]       wb_sel,
  output logic             out_e,
  output logic [3:0]       alu_op,
  output logic [2:0]       phase,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [1:0] op;
  logic [2:0] ra, rb;
  logic [3:0] op3;
  logic       is_alu, is_ld, is_st, is_li, is_b, is_bcc, is_nop, is_hlt, is_mem;
  logic       alu_writes, writes_reg, cond_ok, taken;
  logic       unused_bits;

  assign op  = instruction[15:14];
  assign ra  = instruction[13:11];
  assign rb  = instruction[10:8];
  assign op3 = instruction[7:4];

  // Carry and the low immediate bits only matter to the datapath.
  assign unused_bits = ^{C, instruction[3:0]};

  always_comb begin
    is_alu = (op == 2'b11);
    is_ld  = (op == 2'b00);
    is_st  = (op == 2'b01);
    is_li  = (op == 2'b10) && (ra == 3'b000);
    is_b   = (op == 2'b10) && (ra == 3'b100);
    is_bcc = (op == 2'b10) && (ra == 3'b111) && !rb[2];
    is_nop = !(is_alu || is_ld || is_st || is_li || is_b || is_bcc);
    is_hlt = is_alu && (op3 == 4'hF);
    is_mem = is_ld || is_st;
  end

  always_comb begin
    alu_writes = 1'b0;
    case (op3)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6,
      4'd8, 4'd9, 4'd10, 4'd11, 4'd12: alu_writes = 1'b1;
      default:                         alu_writes = 1'b0;
    endcase
    writes_reg = (is_alu && alu_writes) || is_ld || is_li;
  end

  always_comb begin
    cond_ok = 1'b0;
    case (rb[1:0])
      2'd0:    cond_ok = Z;
      2'd1:    cond_ok = S ^ V;
      2'd2:    cond_ok = Z | (S ^ V);
      default: cond_ok = ~Z;
    endcase
    taken = is_b || (is_bcc && cond_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = mem_ack ? DECODE : FETCH;
      DECODE:  state_d = is_hlt ? HALT : EXEC;
      EXEC:    state_d = (is_mem || (SKIP_MEM == 0)) ? MEM : WB;
      MEM:     state_d = (!is_mem || mem_ack) ? WB : MEM;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // HLT retires on its way into HALT since it never reaches WB.
  always_comb begin
    instret_d = instret_q;
    if ((state_q == WB) || ((state_q == DECODE) && is_hlt))
      instret_d = instret_q + CNT_W'(1);
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_w    = 1'b0;
    addr_sel = 1'b0;
    ir_e     = 1'b0;
    pc_e     = 1'b0;
    pc_sel   = 1'b0;
    ar_e     = 1'b0;
    br_e     = 1'b0;
    alu_e    = 1'b0;
    dr_e     = 1'b0;
    mdr_e    = 1'b0;
    flag_e   = 1'b0;
    reg_w    = 1'b0;
    wb_sel   = 2'd0;
    out_e    = 1'b0;
    alu_op   = 4'd0;
    halted   = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        ir_e    = mem_ack;
        pc_e    = mem_ack;
      end
      DECODE: begin
        ar_e = 1'b1;
        br_e = 1'b1;
      end
      EXEC: begin
        alu_e  = !is_nop;
        dr_e   = !is_nop;
        flag_e = is_alu && (op3 <= 4'd11);
        alu_op = is_alu ? op3 : 4'd0;
      end
      MEM: begin
        // Non-memory classes pass through MEM silently when SKIP_MEM=0.
        if (is_mem) begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_w    = is_st;
          mdr_e    = is_ld && mem_ack;
        end
      end
      WB: begin
        reg_w  = writes_reg;
        out_e  = is_alu && (op3 == 4'd13);
        pc_e   = taken;
        pc_sel = taken;
        if (is_ld)
          wb_sel = 2'd1;
        else if (is_li)
          wb_sel = 2'd2;
        else if (is_alu && (op3 == 4'd12))
          wb_sel = 2'd3;
        else
          wb_sel = 2'd0;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  assign phase   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_seq_control.sv
// tb/tb_seq_control.sv - randomized bench for seq_control against a per-instruction cycle-sequence model
`timescale 1ns/1ps
module tb_seq_control;

  typedef struct packed {
    logic [2:0] phase;
    logic mem_req, mem_w, addr_sel, ir_e, pc_e, pc_sel, ar_e, br_e;
    logic alu_e, dr_e, mdr_e, flag_e, reg_w;
    logic [1:0] wb_sel;
    logic out_e;
    logic [3:0] alu_op;
    logic halted;
  } ctl_t;

  typedef struct {
    ctl_t       w;
    logic [1:0] ack;
    logic [3:0] fl;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, s_f, z_f, c_f, v_f, mem_ack;
  logic [15:0] instruction;

  logic mem_req_a, mem_w_a, addr_sel_a, ir_e_a, pc_e_a, pc_sel_a, ar_e_a, br_e_a;
  logic alu_e_a, dr_e_a, mdr_e_a, flag_e_a, reg_w_a, out_e_a, halted_a;
  logic [1:0] wb_sel_a;
  logic [3:0] alu_op_a;
  logic [2:0] phase_a;
  logic [15:0] instret_a;

  logic mem_req_b, mem_w_b, addr_sel_b, ir_e_b, pc_e_b, pc_sel_b, ar_e_b, br_e_b;
  logic alu_e_b, dr_e_b, mdr_e_b, flag_e_b, reg_w_b, out_e_b, halted_b;
  logic [1:0] wb_sel_b;
  logic [3:0] alu_op_b;
  logic [2:0] phase_b;
  logic [3:0] instret_b;

  seq_control #(.SKIP_MEM(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .instruction(instruction),
    .S(s_f), .Z(z_f), .C(c_f), .V(v_f), .mem_ack(mem_ack),
    .mem_req(mem_req_a), .mem_w(mem_w_a), .addr_sel(addr_sel_a),
    .ir_e(ir_e_a), .pc_e(pc_e_a), .pc_sel(pc_sel_a),
    .ar_e(ar_e_a), .br_e(br_e_a), .alu_e(alu_e_a), .dr_e(dr_e_a),
    .mdr_e(mdr_e_a), .flag_e(flag_e_a), .reg_w(reg_w_a), .wb_sel(wb_sel_a),
    .out_e(out_e_a), .alu_op(alu_op_a), .phase(phase_a), .halted(halted_a),
    .instret(instret_a)
  );

  seq_control #(.SKIP_MEM(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .instruction(instruction),
    .S(s_f), .Z(z_f), .C(c_f), .V(v_f), .mem_ack(mem_ack),
    .mem_req(mem_req_b), .mem_w(mem_w_b), .addr_sel(addr_sel_b),
    .ir_e(ir_e_b), .pc_e(pc_e_b), .pc_sel(pc_sel_b),
    .ar_e(ar_e_b), .br_e(br_e_b), .alu_e(alu_e_b), .dr_e(dr_e_b),
    .mdr_e(mdr_e_b), .flag_e(flag_e_b), .reg_w(reg_w_b), .wb_sel(wb_sel_b),
    .out_e(out_e_b), .alu_op(alu_op_b), .phase(phase_b), .halted(halted_b),
    .instret(instret_b)
  );

  ctl_t obs_a, obs_b;
  assign obs_a = {phase_a, mem_req_a, mem_w_a, addr_sel_a, ir_e_a, pc_e_a, pc_sel_a,
                  ar_e_a, br_e_a, alu_e_a, dr_e_a, mdr_e_a, flag_e_a, reg_w_a,
                  wb_sel_a, out_e_a, alu_op_a, halted_a};
  assign obs_b = {phase_b, mem_req_b, mem_w_b, addr_sel_b, ir_e_b, pc_e_b, pc_sel_b,
                  ar_e_b, br_e_b, alu_e_b, dr_e_b, mdr_e_b, flag_e_b, reg_w_b,
                  wb_sel_b, out_e_b, alu_op_b, halted_b};

  int   n_vec = 0;
  int   n_err = 0;
  bit   sel = 1'b0;
  int   exp_cnt = 0;
  rec_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] cur_word();
    return {8'h0, (sel ? obs_b : obs_a)};
  endfunction

  function automatic logic [31:0] cur_cnt();
    return sel ? {28'h0, instret_b} : {16'h0, instret_a};
  endfunction

  function automatic logic [31:0] exp_instret();
    return sel ? (exp_cnt % 16) : (exp_cnt % 65536);
  endfunction

  task automatic push(input ctl_t e, input logic [1:0] a, input logic [3:0] f);
    rec_t r;
    r.w = e; r.ack = a; r.fl = f;
    q.push_back(r);
  endtask

  // Expected cycle-by-cycle control words for one instruction; ack 2 means mem_ack is don't-care noise.
  task automatic build(input logic [15:0] ins, input int fw, input int mw,
                       input logic [3:0] wfl, input bit skip, input int nh);
    logic [1:0] op; logic [2:0] ra, rb; logic [3:0] op3;
    bit alu, ld, st, li, br, bcc, nop, hlt, wr, tk;
    logic s, z, v;
    ctl_t e;
    op = ins[15:14]; ra = ins[13:11]; rb = ins[10:8]; op3 = ins[7:4];
    alu = (op == 3); ld = (op == 0); st = (op == 1);
    li  = (op == 2) && (ra == 0);
    br  = (op == 2) && (ra == 4);
    bcc = (op == 2) && (ra == 7) && (rb < 4);
    nop = !(alu || ld || st || li || br || bcc);
    hlt = alu && (op3 == 15);
    wr  = ld || li || (alu && (op3 <= 4 || op3 == 6 || (op3 >= 8 && op3 <= 12)));
    {s, z, v} = {wfl[3], wfl[2], wfl[0]};
    tk = br;
    if (bcc) begin
      case (rb)
        0: tk = z;
        1: tk = s ^ v;
        2: tk = z | (s ^ v);
        default: tk = !z;
      endcase
    end
    q.delete();
    for (int i = 0; i < fw; i++) begin
      e = '0; e.phase = 1; e.mem_req = 1; push(e, 0, 4'($urandom));
    end
    e = '0; e.phase = 1; e.mem_req = 1; e.ir_e = 1; e.pc_e = 1; push(e, 1, 4'($urandom));
    e = '0; e.phase = 2; e.ar_e = 1; e.br_e = 1; push(e, 2, 4'($urandom));
    if (hlt) begin
      for (int i = 0; i < nh; i++) begin
        e = '0; e.phase = 6; e.halted = 1; push(e, 2, 4'($urandom));
      end
      return;
    end
    e = '0; e.phase = 3; e.alu_e = !nop; e.dr_e = !nop;
    e.flag_e = alu && (op3 <= 11); e.alu_op = alu ? op3 : 4'd0;
    push(e, 2, 4'($urandom));
    if (ld || st) begin
      for (int i = 0; i < mw; i++) begin
        e = '0; e.phase = 4; e.mem_req = 1; e.addr_sel = 1; e.mem_w = st; push(e, 0, 4'($urandom));
      end
      e = '0; e.phase = 4; e.mem_req = 1; e.addr_sel = 1; e.mem_w = st; e.mdr_e = ld;
      push(e, 1, 4'($urandom));
    end else if (!skip) begin
      e = '0; e.phase = 4; push(e, 2, 4'($urandom));
    end
    e = '0; e.phase = 5; e.reg_w = wr; e.out_e = alu && (op3 == 13);
    e.pc_e = tk; e.pc_sel = tk;
    e.wb_sel = ld ? 2'd1 : li ? 2'd2 : (alu && op3 == 12) ? 2'd3 : 2'd0;
    push(e, 2, wfl);
  endtask

  task automatic play(input int stop, input string nm);
    for (int i = 0; i < q.size(); i++) begin
      if (stop >= 0 && i >= stop) return;
      mem_ack = (q[i].ack == 2) ? 1'($urandom) : q[i].ack[0];
      {s_f, z_f, c_f, v_f} = q[i].fl;
      #4;
      check($sformatf("%s c%0d", nm, i), cur_word(), {8'h0, q[i].w});
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input logic [15:0] ins, input int fw, input int mw,
                     input logic [3:0] wfl, input int nh, input string nm);
    instruction = ins;
    build(ins, fw, mw, wfl, !sel, nh);
    play(-1, nm);
    exp_cnt++;
    check({nm, " instret"}, cur_cnt(), exp_instret());
  endtask

  task automatic idle_cycle();
    ctl_t e;
    e = '0;
    q.delete();
    push(e, 2, 4'($urandom));
    play(-1, "idle");
  endtask

  task automatic reset_dut();
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    mem_ack = 1'b1;
    #2;
    check("rst word", cur_word(), 32'h0);
    check("rst instret", cur_cnt(), 32'h0);
    @(posedge clk); #1;
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    exp_cnt = 0;
    idle_cycle();
  endtask

  function automatic logic [15:0] rand_ins();
    logic [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(3) == 0) begin
      r[15:14] = 2'b10;
      case ($urandom_range(2))
        0:       r[13:11] = 3'b000;
        1:       r[13:11] = 3'b100;
        default: r[13:11] = 3'b111;
      endcase
    end
    if (r[15:14] == 2'b11 && r[7:4] == 4'hF) r[7:4] = 4'h0;
    return r;
  endfunction

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; instruction = 16'h0;
    {s_f, z_f, c_f, v_f} = 4'h0; mem_ack = 1'b0;
    @(posedge clk); #1;

    sel = 1'b0;
    reset_dut();
    run(16'hC000, 0, 0, 4'($urandom), 0, "add");
    run(16'h0905, 0, 2, 4'($urandom), 0, "ld_wait");
    run(16'hB803, 0, 0, 4'b0100, 0, "be_taken");
    run(16'hB803, 1, 0, 4'b1011, 0, "be_not");
    run(16'hBA00, 0, 0, 4'b1000, 0, "ble_taken");
    run(16'hC0D0, 0, 0, 4'($urandom), 0, "out");
    run(16'hC0C0, 2, 0, 4'($urandom), 0, "in");
    run(16'h8012, 0, 0, 4'($urandom), 0, "li");
    run(16'h4000, 0, 1, 4'($urandom), 0, "st");
    run(16'hC070, 0, 0, 4'($urandom), 0, "rsvd");
    run(16'hC050, 0, 0, 4'($urandom), 0, "cmp");
    repeat (60) run(rand_ins(), $urandom_range(2), $urandom_range(2), 4'($urandom), 0, "rnd");
    run(16'hC0F0, 0, 0, 4'($urandom), 6, "hlt");

    reset_dut();
    instruction = 16'h4000;
    build(16'h4000, 0, 3, 4'h0, 1'b1, 0);
    play(4, "st_pre");
    mem_ack = 1'b0;
    #1;
    check("st_wait req/w", {30'h0, mem_req_a, mem_w_a}, 32'h3);
    rst_a = 1'b1;
    #1;
    check("st_rst word", cur_word(), 32'h0);
    check("st_rst instret", cur_cnt(), 32'h0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    exp_cnt = 0;
    idle_cycle();
    check("post_rst phase", {29'h0, phase_a}, 32'h1);
    check("post_rst instret", cur_cnt(), 32'h0);
    run(16'hC000, 0, 0, 4'($urandom), 0, "post_rst_add");

    rst_a = 1'b1;
    sel = 1'b1;
    reset_dut();
    repeat (16) run(16'hC000, $urandom_range(1), 0, 4'($urandom), 0, "b_add");
    check("b_wrap", cur_cnt(), 32'h0);
    repeat (30) run(rand_ins(), $urandom_range(2), $urandom_range(2), 4'($urandom), 0, "b_rnd");
    run(16'hC0F0, 1, 0, 4'($urandom), 3, "b_hlt");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_control.md
SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 Parameter SKIP_MEM, default 1: 1 means non-memory instructions bypass MEM; 0 means every instruction spends exactly one MEM cycle.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 instruction  in  16  IR contents; valid from DECODE onward.
REQ-007 S, Z, C, V  in  1 each  ALU flags: sign, zero, carry, overflow.
REQ-008 mem_ack  in  1  memory completion, sampled while mem_req=1.
REQ-009 mem_req, mem_w, addr_sel  out  1 each  memory request, write strobe, address select (0=PC, 1=DR).
REQ-010 ir_e, pc_e, pc_sel  out  1 each  IR load, PC load, PC source (0=PC+1, 1=PC+1+sext(d8)).
REQ-011 ar_e, br_e, alu_e, dr_e, mdr_e, flag_e  out  1 each  datapath register/ALU enables.
REQ-012 reg_w  out  1  register-file write.
REQ-013 wb_sel  out  2  write-back source (0=DR, 1=MDR, 2=sext(d8), 3=input port).
REQ-014 out_e  out  1  output-port load.
REQ-015 alu_op  out  4  ALU function; instruction[7:4] for op=11, 0000 (ADD) otherwise.
REQ-016 phase  out  3  current state encoding.
REQ-017 halted  out  1  high in HALT.
REQ-018 instret  out  CNT_W  retired-instruction count.

Function
REQ-019 Decode fields: op=[15:14], Ra=[13:11], Rb=[10:8], op3=[7:4], d8=[7:0].
REQ-020 Instruction classes:
- op=11: ALU (op3 0-6 ADD,SUB,AND,OR,XOR,CMP,MOV; 8-11 SLL,SLR,SRL,SRA; 12 IN; 13 OUT; 15 HLT; 7 and 14 reserved).
- op=00: LD.
- op=01: ST.
- op=10, Ra=000: LI.
- op=10, Ra=100: B.
- op=10, Ra=111, Rb=000..011: BE, BLT, BLE, BNE.
- Any other encoding: NOP.
REQ-021 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
REQ-022 IDLE -> FETCH unconditionally.
REQ-023 FETCH: mem_req=1, addr_sel=0; stays until mem_ack=1; on the ack cycle ir_e=1 and pc_e=1 with pc_sel=0, then -> DECODE.
REQ-024 DECODE: ar_e=br_e=1; HLT -> HALT; all else -> EXEC.
REQ-025 EXEC: alu_e=dr_e=1 for every class except NOP; flag_e=1 only for op3 in 0-11.
REQ-026 After EXEC:
- LD, ST: -> MEM.
- Other classes: -> WB when SKIP_MEM=1, -> MEM when SKIP_MEM=0.
REQ-027 MEM for LD/ST: mem_req=1, addr_sel=1, mem_w=1 for ST only; stays until mem_ack=1; mdr_e=1 on the ack cycle for LD only; then -> WB.
REQ-028 MEM for any other class: one cycle, all outputs low, then -> WB.
REQ-029 WB: reg_w=1 for ADD-XOR, MOV, shifts, IN, LD, LI; wb_sel per REQ-013.
REQ-030 WB: reg_w=0 for CMP, OUT, ST, branches, reserved, NOP; out_e=1 for OUT.
REQ-031 WB: pc_e=1 with pc_sel=1 for B always; for BE when Z; BLT when S^V; BLE when Z|(S^V); BNE when ~Z; flags are sampled in the WB cycle. WB -> FETCH.
REQ-032 HALT: all enables 0, halted=1; remains until rst.
REQ-033 Latency with zero wait states (mem_ack high in the first request cycle):
- ALU op: 4 cycles FETCH-to-FETCH with SKIP_MEM=1, 5 with SKIP_MEM=0.
- LD/ST: 5 cycles.
- Each wait cycle adds 1.
REQ-034 instret increments by 1 in every WB cycle and on HALT entry; it wraps from 2^CNT_W-1 to 0.
REQ-035 In any cycle, mem_w=1 implies mem_req=1; ir_e and reg_w are never high together.
REQ-036 mem_ack while mem_req=0 is ignored.

Reset
REQ-037 While rst=1: state=IDLE, instret=0, and every output is 0 (phase=0, halted=0).
REQ-038 rst asserted mid-instruction, including during a MEM wait, drops mem_req and all enables immediately (asynchronously) with no write completed.
REQ-039 After rst falls, the first rising edge enters FETCH.

Verification
REQ-040 ADD (0xC000) with mem_ack always 1, SKIP_MEM=1 -> phases 1,2,3,5,1; flag_e in EXEC; reg_w=1, wb_sel=0 in WB; instret 0->1.
REQ-041 LD (0x0905) with mem_ack delayed 2 cycles in MEM -> mem_req=1, addr_sel=1 for 3 cycles; mdr_e on the third; WB wb_sel=1, reg_w=1; 7 cycles total.
REQ-042 BE (0xB803) with Z=1 -> WB pc_e=1, pc_sel=1. With Z=0 -> pc_e=0. BLE with Z=0, S=1, V=0 -> taken.
REQ-043 HLT (0xC0F0) -> DECODE then HALT; halted=1; instret=1; mem_ack pulses produce no change.
REQ-044 rst during ST MEM wait -> mem_req=0 and mem_w=0 in the same cycle; after release, FETCH with instret=0.
REQ-045 CNT_W=4, 16 ADDs -> instret wraps to 0; SKIP_MEM=0 -> ADD takes 5 cycles.
